// File: rtl/nibble_serial_subtractor_32.sv
// Slice-serial ripple-borrow subtractor: diff = a - b - b_in, SLICE bits per clock.
// Operands and results move through independent valid/ready handshakes; no overlap.
module nibble_serial_subtractor_32 #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             b_in_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             b_out_o,
  output logic             zero_o,
  output logic             neg_o,
  output logic             ovf_o
);

  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSL - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, diff_q, diff_d;
  logic             borrow_q, out_valid_q;
  logic             b_out_q, zero_q, neg_q, ovf_q;
  logic             accept, last;

  logic [SLICE-1:0] sl_a, sl_b, sl_d;
  logic [SLICE:0]   bw;

  assign accept = in_valid_i && in_ready_o;
  assign last   = (state_q == RUN) && (cnt_q == LAST);

  // Ripple-borrow chain for the slice selected by the counter
  always_comb begin
    sl_a  = a_q[cnt_q*SLICE +: SLICE];
    sl_b  = b_q[cnt_q*SLICE +: SLICE];
    bw    = '0;
    sl_d  = '0;
    bw[0] = borrow_q;
    for (int i = 0; i < SLICE; i++) begin
      sl_d[i]  = sl_a[i] ^ sl_b[i] ^ bw[i];
      bw[i+1]  = (~sl_a[i] & sl_b[i]) | (~(sl_a[i] ^ sl_b[i]) & bw[i]);
    end
    diff_d = diff_q;
    diff_d[cnt_q*SLICE +: SLICE] = sl_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)      state_d = RUN;
      RUN:     if (last)        state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o = (state_q == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      borrow_q    <= 1'b0;
      cnt_q       <= '0;
      diff_q      <= '0;
      b_out_q     <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= (state_d == DONE);
      if (accept) begin
        a_q      <= a_i;
        b_q      <= b_i;
        borrow_q <= b_in_i;
        cnt_q    <= '0;
      end else if (state_q == RUN) begin
        diff_q   <= diff_d;
        borrow_q <= bw[SLICE];
        cnt_q    <= last ? '0 : cnt_q + 1'b1;
        if (last) begin
          b_out_q <= bw[SLICE];
          zero_q  <= (diff_d == '0);
          neg_q   <= diff_d[WIDTH-1];
          // Final slice: bw[SLICE-1] is the borrow into the MSB
          ovf_q   <= bw[SLICE-1] ^ bw[SLICE];
        end
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign diff_o      = diff_q;
  assign b_out_o     = b_out_q;
  assign zero_o      = zero_q;
  assign neg_o       = neg_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_subtractor_32.sv
// Directed and randomized self-checking bench for nibble_serial_subtractor_32.
module tb_nibble_serial_subtractor_32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        b_in_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] diff_o;
  logic        b_out_o, zero_o, neg_o, ovf_o;

  int tests_run = 0;
  int tests_failed = 0;

  nibble_serial_subtractor_32 #(.WIDTH(32), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .a_i(a_i), .b_i(b_i), .b_in_i(b_in_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .diff_o(diff_o), .b_out_o(b_out_o), .zero_o(zero_o), .neg_o(neg_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  // Issue one operation from IDLE and collect its result. Called at #1 after a posedge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                        input bit rnd_ready, output logic [31:0] d, output logic bo,
                        output logic z, output logic n, output logic o,
                        output int lat, output bit to);
    int w;
    bit r;
    a_i = a; b_i = b; b_in_i = bin; in_valid_i = 1'b1;
    w = 0;
    while (!in_ready_o && w < 20) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    a_i = $urandom; b_i = $urandom; b_in_i = 1'($urandom_range(0, 1));
    lat = 0;
    while (!out_valid_o && lat < 50) begin @(posedge clk); #1; lat++; end
    to = !out_valid_o;
    d = diff_o; bo = b_out_o; z = zero_o; n = neg_o; o = ovf_o;
    w = 0;
    do begin
      r = rnd_ready ? ((w == 19) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b1;
      out_ready_i = r;
      @(posedge clk); #1;
      w++;
    end while (!r);
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || diff_o !== 32'h0 ||
        b_out_o !== 1'b0 || zero_o !== 1'b0 || neg_o !== 1'b0 || ovf_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: rdy=%b vld=%b diff=%h bo=%b z=%b n=%b o=%b expected rdy=1 vld=0 all else 0",
               in_ready_o, out_valid_o, diff_o, b_out_o, zero_o, neg_o, ovf_o);
    end
  endtask

  task automatic test_basic();
    logic [31:0] d; logic bo, z, n, o; int lat; bit to;
    run_op(32'd5, 32'd3, 1'b0, 1'b0, d, bo, z, n, o, lat, to);
    tests_run++;
    if (to || lat !== 8) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d (timeout=%0d) expected 8", lat, to);
    end
    tests_run++;
    if (d !== 32'h2 || bo !== 1'b0 || z !== 1'b0 || n !== 1'b0 || o !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_5_minus_3: diff=%h bo=%b z=%b n=%b o=%b expected 00000002 0 0 0 0", d, bo, z, n, o);
    end
    tests_run++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_after_handshake: rdy=%b vld=%b expected rdy=1 vld=0", in_ready_o, out_valid_o);
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] d; logic bo, z, n, o; int lat; bit to;
    run_op(32'h0, 32'h1, 1'b0, 1'b0, d, bo, z, n, o, lat, to);
    tests_run++;
    if (to || d !== 32'hFFFF_FFFF || bo !== 1'b1 || z !== 1'b0 || n !== 1'b1 || o !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_0_minus_1: diff=%h bo=%b z=%b n=%b o=%b expected ffffffff 1 0 1 0", d, bo, z, n, o);
    end
    run_op(32'h8000_0000, 32'h1, 1'b0, 1'b0, d, bo, z, n, o, lat, to);
    tests_run++;
    if (to || d !== 32'h7FFF_FFFF || bo !== 1'b0 || z !== 1'b0 || n !== 1'b0 || o !== 1'b1) begin
      tests_failed++;
      $display("FAIL signed_ovf: diff=%h bo=%b z=%b n=%b o=%b expected 7fffffff 0 0 0 1", d, bo, z, n, o);
    end
    run_op(32'h1234_5678, 32'h1234_5677, 1'b1, 1'b0, d, bo, z, n, o, lat, to);
    tests_run++;
    if (to || d !== 32'h0 || bo !== 1'b0 || z !== 1'b1 || n !== 1'b0 || o !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_with_bin: diff=%h bo=%b z=%b n=%b o=%b expected 00000000 0 1 0 0", d, bo, z, n, o);
    end
    run_op(32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, d, bo, z, n, o, lat, to);
    tests_run++;
    if (to || d !== 32'h0 || bo !== 1'b1 || z !== 1'b1 || n !== 1'b0 || o !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_borrow_zero: diff=%h bo=%b z=%b n=%b o=%b expected 00000000 1 1 0 0", d, bo, z, n, o);
    end
    run_op(32'hABCD_0123, 32'hABCD_0123, 1'b0, 1'b0, d, bo, z, n, o, lat, to);
    tests_run++;
    if (to || d !== 32'h0 || bo !== 1'b0 || z !== 1'b1) begin
      tests_failed++;
      $display("FAIL equal_operands: diff=%h bo=%b z=%b expected 00000000 0 1", d, bo, z);
    end
  endtask

  task automatic test_backpressure();
    int w;
    a_i = 32'h0; b_i = 32'h2; b_in_i = 1'b0; in_valid_i = 1'b1;
    @(posedge clk); #1;
    a_i = 32'd9; b_i = 32'd9;
    w = 0;
    while (!out_valid_o && w < 50) begin @(posedge clk); #1; w++; end
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0 || diff_o !== 32'hFFFF_FFFE ||
          b_out_o !== 1'b1 || zero_o !== 1'b0 || neg_o !== 1'b1 || ovf_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL backpressure_hold[%0d]: vld=%b rdy=%b diff=%h bo=%b z=%b n=%b o=%b expected 1 0 fffffffe 1 0 1 0",
                 k, out_valid_o, in_ready_o, diff_o, b_out_o, zero_o, neg_o, ovf_o);
      end
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    tests_run++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || diff_o !== 32'hFFFF_FFFE) begin
      tests_failed++;
      $display("FAIL backpressure_no_capture: vld=%b rdy=%b diff=%h expected 0 1 fffffffe",
               out_valid_o, in_ready_o, diff_o);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] d; logic bo, z, n, o; int lat; bit to;
    a_i = 32'hFFFF_FFFF; b_i = 32'h1; b_in_i = 1'b0; in_valid_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || diff_o !== 32'h0 || b_out_o !== 1'b0 ||
        zero_o !== 1'b0 || neg_o !== 1'b0 || ovf_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_abort: vld=%b rdy=%b diff=%h bo=%b z=%b n=%b o=%b expected 0 1 00000000 0 0 0 0",
               out_valid_o, in_ready_o, diff_o, b_out_o, zero_o, neg_o, ovf_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'd100, 32'd58, 1'b0, 1'b0, d, bo, z, n, o, lat, to);
    tests_run++;
    if (to || lat !== 8 || d !== 32'd42 || bo !== 1'b0 || z !== 1'b0 || n !== 1'b0 || o !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_reset_op: lat=%0d diff=%h bo=%b z=%b n=%b o=%b expected 8 0000002a 0 0 0 0",
               lat, d, bo, z, n, o);
    end
  endtask

  task automatic test_throughput();
    int stamps[$];
    bit seen_bad;
    a_i = 32'd7; b_i = 32'd2; b_in_i = 1'b0; in_valid_i = 1'b1; out_ready_i = 1'b1;
    seen_bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid_o) begin
        stamps.push_back(c);
        if (diff_o !== 32'd5) seen_bad = 1'b1;
      end
    end
    in_valid_i = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    out_ready_i = 1'b0;
    tests_run++;
    if (stamps.size() < 3 || seen_bad) begin
      tests_failed++;
      $display("FAIL throughput_results: got %0d results (bad diff=%0d) expected >=3 of 00000005",
               stamps.size(), seen_bad);
    end else begin
      for (int k = 1; k < stamps.size(); k++) begin
        tests_run++;
        if (stamps[k] - stamps[k-1] !== 10) begin
          tests_failed++;
          $display("FAIL throughput_interval[%0d]: got %0d clocks expected 10", k, stamps[k] - stamps[k-1]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] spec_v [3];
    logic [31:0] a, b, d, ed;
    logic bin, bo, z, n, o, eb, ez, en, eo;
    logic [32:0] wide;
    longint s;
    int lat, got;
    bit to;
    spec_v[0] = 32'h0; spec_v[1] = 32'h8000_0000; spec_v[2] = 32'hFFFF_FFFF;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      if (i < 9) begin a = spec_v[i/3]; b = spec_v[i%3]; end
      else begin a = $urandom; b = $urandom; end
      bin = 1'($urandom_range(0, 1));
      wide = {1'b0, a} - {1'b0, b} - {32'h0, bin};
      ed = wide[31:0];
      eb = wide[32];
      ez = (ed == 32'h0);
      en = ed[31];
      s = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
      eo = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      run_op(a, b, bin, 1'b1, d, bo, z, n, o, lat, to);
      if (!to) got++;
      tests_run++;
      if (to || d !== ed || bo !== eb || z !== ez || n !== en || o !== eo) begin
        tests_failed++;
        $display("FAIL b2b[%0d] a=%h b=%h bin=%b: diff=%h bo=%b z=%b n=%b o=%b to=%0d expected %h %b %b %b %b",
                 i, a, b, bin, d, bo, z, n, o, to, ed, eb, ez, en, eo);
      end
    end
    tests_run++;
    if (got !== 50) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d results expected 50", got);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_boundaries();
    test_backpressure();
    test_reset_abort();
    test_throughput();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
